bram_rr_arbiter: RTL and testbench
==================================

// Module: bram_rr_arbiter
// PURPOSE
//   Shares one port of a single-port-usage bram_param instance between two requesters
//   (e.g. bin load engine, bin store engine) with round-robin arbitration.
//   Routes 1-cycle-latency read data back to the requester that issued the read.
//   Contains a clear sequencer that zero-fills the whole memory on command.
//   Sits between the bin_manager engines and the var-state / level-state BRAMs.
// PARAMETERS
//   DATA_WIDTH  16    BRAM word width
//   ADDR_WIDTH  10    BRAM address width
//   DEPTH       1024  words to clear; 1 <= DEPTH <= 2**ADDR_WIDTH
// PORTS
//   clk         in   1           single clock; all logic on posedge
//   rst         in   1           synchronous, active-high reset
//   req0/req1   in   1           access request, requester 0/1
//   we0/we1     in   1           1 = write, 0 = read
//   addr0/addr1 in   ADDR_WIDTH  access address
//   wdata0/1    in   DATA_WIDTH  write data
//   gnt0/gnt1   out  1           combinational grant; access is performed this cycle
//   rvalid0/1   out  1           registered; read data valid for requester 0/1
//   rdata0/1    out  DATA_WIDTH  read data, valid while rvalid asserted
//   clear_start in   1           pulse: start zero-fill of addresses 0..DEPTH-1
//   busy        out  1           registered; 1 while clear in progress
//   clear_done  out  1           registered; 1-cycle pulse when clear completes
//   bram_we     out  1           to BRAM wea
//   bram_addr   out  ADDR_WIDTH  to BRAM addra
//   bram_din    out  DATA_WIDTH  to BRAM dina
//   bram_dout   in   DATA_WIDTH  from BRAM douta; valid the cycle after addr presented
// BEHAVIOUR
//   FSM: IDLE (arbitrate) / CLEAR (sequencer owns port). Reset -> IDLE.
//   Reset values: prio=0, rvalid0/1=0, busy=0, clear_done=0, clr_addr=0.
//   Grants are combinational from req*, prio and state; at most one gnt per cycle.
//   IDLE: only reqX -> gntX. Both -> grant requester indicated by prio.
//     After a grant to X, prio <= other requester (registered). No grant: prio unchanged.
//   Granted cycle T: bram_we/addr/din = granted we/addr/wdata.
//   No grant: bram_we=0, bram_addr=0, bram_din=0.
//   Read granted in T: rvalidX=1 in T+1, rdataX = bram_dout (1-cycle latency, not buffered).
//     rdataX is 0 when rvalidX=0; the other requester's rvalid stays 0.
//   Write granted in T: no rvalid. A read of the same address in T+1 returns the new data.
//   Non-granted requester holds req/we/addr/wdata until granted (requester rule; not checked).
//   clear_start in IDLE: -> CLEAR next cycle; busy=1 from that cycle.
//     Same-cycle request arbitration still proceeds normally.
//   CLEAR: gnt0=gnt1=0; each cycle bram_we=1, bram_addr=clr_addr, bram_din=0; clr_addr++.
//     A read granted in the cycle before CLEAR still returns rvalid/rdata.
//     At clr_addr==DEPTH-1: write it, next cycle -> IDLE, busy=0, clear_done=1 (1 cycle), clr_addr=0.
//     Terminal test is compare to DEPTH-1, never ADDR_WIDTH wrap. CLEAR lasts exactly DEPTH cycles.
//   clear_start while in CLEAR: ignored (no restart, no extra clear_done).
//   rst mid-clear: abort immediately, IDLE, no clear_done. Memory is left partially cleared.
//   rst also drops any pending rvalid.
// TESTING
//   1. req0 read addr 5 (mem[5]=16'hBEEF), req1=0 -> gnt0 same cycle; next cycle rvalid0=1, rdata0=16'hBEEF.
//   2. req0,req1 held together from reset for 4 cycles -> gnt order 0,1,0,1; each rvalid follows its grant by 1.
//   3. req1 write addr 9=16'h1234 then req0 read addr 9 next cycle -> rdata0=16'h1234.
//   4. clear_start with DEPTH=16, mem prefilled -> busy 16 cycles, gnt0/1=0 while req held, clear_done pulse, all 16 words 0.
//   5. rst asserted at clear cycle 7 -> IDLE next cycle, busy=0, no clear_done; addresses 0..6 zero, 7..15 intact.
//   6. clear_start pulsed again during CLEAR -> exactly one clear_done, total busy = DEPTH cycles.

Source files
------------

// File: rtl/bram_rr_arbiter_if.sv
// Bundle of the requester, clear-control and BRAM-side signals around bram_rr_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// requesters, the clear controller and the BRAM itself.
interface bram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  clear_start;
  logic                  busy;
  logic                  clear_done;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clear_start, bram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, clear_done,
           bram_we, bram_addr, bram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clear_start, bram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, clear_done,
           bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin sharing of one BRAM port between two requesters, with read-data return
// routing and a zero-fill sequencer that owns the port for DEPTH cycles on command.
module bram_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input logic                clk,
  input logic                rst,
  bram_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q;
  logic                  prio_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  busy_q;
  logic                  clear_done_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic                  gnt0;
  logic                  gnt1;

  // Grants: only in IDLE; on contention the requester named by prio_q wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = bus.req0 & (~bus.req1 | ~prio_q);
      gnt1 = bus.req1 & (~bus.req0 |  prio_q);
    end
  end

  // BRAM port mux: sequencer during CLEAR, else the granted requester, else idle zeros.
  always_comb begin
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_din  = '0;
    if (state_q == CLEAR) begin
      bus.bram_we   = 1'b1;
      bus.bram_addr = clr_addr_q;
    end else if (gnt0) begin
      bus.bram_we   = bus.we0;
      bus.bram_addr = bus.addr0;
      bus.bram_din  = bus.wdata0;
    end else if (gnt1) begin
      bus.bram_we   = bus.we1;
      bus.bram_addr = bus.addr1;
      bus.bram_din  = bus.wdata1;
    end
  end

  // Control FSM with registered status: priority rotation, read-return tags, clear sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      clr_addr_q   <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      rvalid0_q    <= gnt0 & ~bus.we0;
      rvalid1_q    <= gnt1 & ~bus.we1;
      if (gnt0) begin
        prio_q <= 1'b1;
      end else if (gnt1) begin
        prio_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (bus.clear_start) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
          end
        end
        CLEAR: begin
          // Terminal compare against DEPTH-1 so a partial-depth clear never relies on wrap.
          if (clr_addr_q == LAST_ADDR) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
            clr_addr_q   <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  // Read data is the raw BRAM output, gated so it reads zero when not valid.
  assign bus.rdata0     = rvalid0_q ? bus.bram_dout : '0;
  assign bus.rdata1     = rvalid1_q ? bus.bram_dout : '0;
  assign bus.busy       = busy_q;
  assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural 1-cycle-latency BRAM model.
module tb_bram_rr_arbiter;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  bram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM model
  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= mem[bus.bram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.clear_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hA000 + 16'(i);
    mem[5] = 16'hBEEF;

    // Reset state
    do_reset();
    #1;
    chk("rst_busy",   32'(bus.busy),       32'h0);
    chk("rst_done",   32'(bus.clear_done), 32'h0);
    chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 32'h0);
    chk("rst_bram",   {bus.bram_we, 11'(bus.bram_addr), bus.bram_din}, 32'h0);

    // Test 2: both requesters from reset, grant order 0,1,0,1
    bus.req0 = 1'b1; bus.addr0 = 5'd3;
    bus.req1 = 1'b1; bus.addr1 = 5'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt",  {bus.gnt0, bus.gnt1}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("rr_addr", 32'(bus.bram_addr), (k % 2 == 0) ? 32'd3 : 32'd4);
      tick();
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      chk("rr_rvalid", {bus.rvalid0, bus.rvalid1}, (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("rr_rdata0", 32'(bus.rdata0), (k % 2 == 0) ? 32'hA003 : 32'h0);
      chk("rr_rdata1", 32'(bus.rdata1), (k % 2 == 0) ? 32'h0 : 32'hA004);
    end

    // Test 1: lone read by requester 0
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd5;
    #1;
    chk("rd_gnt", {bus.gnt0, bus.gnt1}, 32'h2);
    chk("rd_bram", {bus.bram_we, 11'(bus.bram_addr)}, 32'h5);
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("rd_rvalid", {bus.rvalid0, bus.rvalid1}, 32'h2);
    chk("rd_rdata0", 32'(bus.rdata0), 32'hBEEF);
    chk("rd_rdata1", 32'(bus.rdata1), 32'h0);

    // Test 3: write by requester 1, read-back by requester 0
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 5'd9; bus.wdata1 = 16'h1234;
    #1;
    chk("wr_gnt",  {bus.gnt0, bus.gnt1}, 32'h1);
    chk("wr_bram", {bus.bram_we, 11'(bus.bram_addr), bus.bram_din}, {1'b1, 11'd9, 16'h1234});
    tick();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 5'd9;
    #1;
    chk("wr_no_rvalid", {bus.rvalid0, bus.rvalid1}, 32'h0);
    chk("wr_rd_gnt", {bus.gnt0, bus.gnt1}, 32'h2);
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("wr_rd_rvalid", 32'(bus.rvalid0), 32'h1);
    chk("wr_rd_rdata",  32'(bus.rdata0), 32'h1234);

    // Tests 4 and 6: clear with same-cycle read, requests held, extra clear_start mid-clear
    bus.clear_start = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 5'd5;
    #1;
    chk("clr_pre_gnt", {bus.gnt0, bus.gnt1}, 32'h2);
    tick();
    bus.req1 = 1'b1; bus.addr1 = 5'd6;
    #1;
    chk("clr_rvalid", 32'(bus.rvalid0), 32'h1);
    chk("clr_rdata",  32'(bus.rdata0),  32'hBEEF);
    for (int c = 0; c < DEPTH; c++) begin
      bus.clear_start = (c == 3);
      #1;
      chk("clr_gnt",  {bus.gnt0, bus.gnt1}, 32'h0);
      chk("clr_bram", {bus.bram_we, 11'(bus.bram_addr), bus.bram_din}, {1'b1, 11'(c), 16'h0});
      chk("clr_busy", {bus.busy, bus.clear_done}, 32'h2);
      tick();
    end
    bus.clear_start = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
    chk("clr_end", {bus.busy, bus.clear_done}, 32'h1);
    tick();
    chk("clr_done_pulse", {bus.busy, bus.clear_done}, 32'h0);
    tick();
    chk("clr_no_extra", {bus.busy, bus.clear_done}, 32'h0);
    for (int i = 0; i < DEPTH; i++) chk("clr_mem_zero", 32'(mem[i]), 32'h0);
    chk("clr_mem_beyond", 32'(mem[DEPTH]), 32'hA010);

    // Test 5: reset during the 7th clear cycle (clr_addr 6)
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hC000 + 16'(i);
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    #1;
    chk("abort_addr", 32'(bus.bram_addr), 32'd6);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_state", {bus.busy, bus.clear_done, bus.bram_we}, 32'h0);
    tick();
    chk("abort_no_done", {bus.busy, bus.clear_done}, 32'h0);
    for (int i = 0; i < DEPTH; i++)
      chk("abort_mem", 32'(mem[i]), (i < 7) ? 32'h0 : 32'(16'hC000 + 16'(i)));

    // Clear restarts from address 0 after an abort
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    #1;
    chk("restart_addr", {bus.busy, bus.bram_we, 11'(bus.bram_addr)}, {2'b11, 11'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset drops a pending read return
    bus.req0 = 1'b1; bus.addr0 = 5'd20;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("rst_drops_rvalid", {bus.rvalid0, bus.rvalid1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required completion before 100000");
    $fatal(1, "timeout");
  end
endmodule
